// File: rtl/digi_ota_pkg.sv
// Shared types and sizing for the OTA PWM stimulus / comparator-count block.
//   FRAME_W    : width of the PWM frame counter and duty values
//   FRAMES_W   : width of the measurement-length field
//   RESULT_W   : width of the accumulator and result
//   MAX_FRAMES : measurement length used when the frames field is 0
package digi_ota_pkg;

    localparam int unsigned FRAME_W    = 8;
    localparam int unsigned FRAMES_W   = 4;
    localparam int unsigned RESULT_W   = 13;
    localparam int unsigned MAX_FRAMES = 16;

    typedef enum logic [1:0] {
        StIdle,
        StAlign,
        StMeasure,
        StDone
    } state_e;

    // Number of frames a measurement spans; a zero field selects the maximum.
    function automatic int unsigned frame_count(input logic [FRAMES_W-1:0] frames);
        return (frames == '0) ? MAX_FRAMES : 32'(frames);
    endfunction

endpackage

// File: rtl/digi_ota_stim_if.sv
// Bus bundle between the OTA stimulus block and its controller.
//   ena     : block enable
//   duty_p  : vip high-time per 256-cycle frame
//   duty_n  : vin high-time per 256-cycle frame
//   start   : single-cycle measurement request
//   frames  : measurement length in frames (0 = 16)
//   ota_out : raw comparator output (asynchronous)
//   vip/vin : PWM drives to the OTA inputs
//   busy    : measurement in progress
//   done    : one-cycle completion pulse
//   result  : sampled-high count of the last completed measurement
interface digi_ota_stim_if
    import digi_ota_pkg::*;
;
    logic                ena;
    logic [FRAME_W-1:0]  duty_p;
    logic [FRAME_W-1:0]  duty_n;
    logic                start;
    logic [FRAMES_W-1:0] frames;
    logic                ota_out;
    logic                vip;
    logic                vin;
    logic                busy;
    logic                done;
    logic [RESULT_W-1:0] result;

    modport master (
        output ena, duty_p, duty_n, start, frames, ota_out,
        input  vip, vin, busy, done, result
    );

    modport slave (
        input  ena, duty_p, duty_n, start, frames, ota_out,
        output vip, vin, busy, done, result
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset (clears both flops)
//   d_i    : asynchronous input
//   q_o    : synchronized output, two clk_i cycles of latency
module sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/digi_ota_stim.sv
// Digital stimulus and measurement for an OTA comparator test.
// Two frame-aligned PWM outputs drive the OTA inputs; a measurement counts
// how many cycles the synchronized comparator output is high over a whole
// number of 256-cycle frames.
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset (deassertion synchronized upstream)
//   bus_io : slave side of digi_ota_stim_if (controls, ota_out, PWM, status)
module digi_ota_stim
    import digi_ota_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    digi_ota_stim_if.slave bus_io
);

    logic [FRAME_W-1:0]  cnt_q;
    logic [FRAME_W-1:0]  shadow_p_q;
    logic [FRAME_W-1:0]  shadow_n_q;
    logic                vip_q;
    logic                vin_q;
    logic                ota_s;
    logic                frame_end;

    state_e              state_q;
    logic [FRAMES_W-1:0] last_frame_q;
    logic [FRAMES_W-1:0] frame_idx_q;
    logic [RESULT_W-1:0] acc_q;
    logic [RESULT_W-1:0] result_q;
    logic                busy_q;
    logic                done_q;

    assign frame_end = (cnt_q == '1);

    sync2 u_sync_ota (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (bus_io.ota_out),
        .q_o    (ota_s)
    );

    // PWM: duties are only picked up on the last cycle of a frame so a
    // frame is always generated from one consistent pair of duty values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            shadow_p_q <= '0;
            shadow_n_q <= '0;
            vip_q      <= 1'b0;
            vin_q      <= 1'b0;
        end else if (bus_io.ena) begin
            cnt_q <= cnt_q + FRAME_W'(1);
            if (frame_end) begin
                shadow_p_q <= bus_io.duty_p;
                shadow_n_q <= bus_io.duty_n;
            end
            vip_q <= (cnt_q < shadow_p_q);
            vin_q <= (cnt_q < shadow_n_q);
        end else begin
            vip_q <= 1'b0;
            vin_q <= 1'b0;
        end
    end

    // Measurement FSM. ALIGN waits for a frame boundary so MEASURE always
    // covers whole frames; frame_idx_q counts completed frames in MEASURE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_frame_q <= '0;
            frame_idx_q  <= '0;
            acc_q        <= '0;
            result_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else if (!bus_io.ena) begin
            // Abort: result keeps the last completed measurement.
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus_io.start) begin
                        state_q      <= StAlign;
                        last_frame_q <= FRAMES_W'(frame_count(bus_io.frames) - 1);
                        busy_q       <= 1'b1;
                    end
                end
                StAlign: begin
                    if (frame_end) begin
                        state_q     <= StMeasure;
                        acc_q       <= '0;
                        frame_idx_q <= '0;
                    end
                end
                StMeasure: begin
                    acc_q <= acc_q + RESULT_W'(ota_s);
                    if (frame_end) begin
                        if (frame_idx_q == last_frame_q) begin
                            state_q  <= StDone;
                            result_q <= acc_q + RESULT_W'(ota_s);
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            frame_idx_q <= frame_idx_q + FRAMES_W'(1);
                        end
                    end
                end
                StDone: begin
                    // start is deliberately not looked at here.
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_io.vip    = vip_q;
    assign bus_io.vin    = vin_q;
    assign bus_io.busy   = busy_q;
    assign bus_io.done   = done_q;
    assign bus_io.result = result_q;

endmodule

// File: tb/tb_digi_ota_stim.sv
// Self-checking bench for digi_ota_stim: reset values, PWM duty and
// frame-boundary behaviour, a table of measurement vectors, and
// hand-written sequences for start-while-busy, enable drop and reset abort.
module tb_digi_ota_stim;
    import digi_ota_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic loop_en = 1'b0;
    logic ota_tie = 1'b0;

    always #5 clk = ~clk;

    digi_ota_stim_if bus ();

    // Comparator source: a constant or the vip drive looped back.
    assign bus.ota_out = loop_en ? bus.vip : ota_tie;

    digi_ota_stim dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    typedef struct {
        logic [7:0] duty_p;
        logic [3:0] frames;
        int         mode;       // 0: ota tied low, 1: tied high, 2: looped from vip
        int         exp_result;
    } vec_t;

    vec_t vecs[7];

    int n_vec = 0;
    int n_bad = 0;
    int model_cnt = 0;  // expected value of the frame counter

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_cnt = 0;
        else if (bus.ena) model_cnt = (model_cnt + 1) % 256;
        #1;
    endtask

    task automatic count_pwm(input int n, output int vh, output int nh);
        vh = 0;
        nh = 0;
        repeat (n) begin
            tick();
            vh += int'(bus.vip);
            nh += int'(bus.vin);
        end
    endtask

    task automatic count_done(input int n, output int dn);
        dn = 0;
        repeat (n) begin
            tick();
            dn += int'(bus.done);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int c;
        int nfr;
        int exp_lat;
        int n;
        bus.duty_p = v.duty_p;
        bus.duty_n = 8'd0;
        bus.frames = v.frames;
        loop_en    = (v.mode == 2);
        ota_tie    = (v.mode == 1);
        repeat (768) tick();
        c       = model_cnt;
        nfr     = (v.frames == 4'd0) ? 16 : int'(v.frames);
        exp_lat = 2 + (255 - ((c + 1) % 256)) + nfr * 256;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 1;
        check($sformatf("vec%0d_busy_rise", idx), int'(bus.busy), 1);
        while (!bus.done && n < 17 * 256 + 600) begin
            tick();
            n++;
        end
        check($sformatf("vec%0d_done_latency", idx), n, exp_lat);
        check($sformatf("vec%0d_result", idx), int'(bus.result), v.exp_result);
        check($sformatf("vec%0d_busy_at_done", idx), int'(bus.busy), 0);
        tick();
        check($sformatf("vec%0d_done_width", idx), int'(bus.done), 0);
        check($sformatf("vec%0d_result_hold", idx), int'(bus.result), v.exp_result);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int vh;
        int nh;
        int dn;
        int n;

        vecs[0] = '{8'd0,   4'd2, 1, 512};
        vecs[1] = '{8'd0,   4'd2, 0, 0};
        vecs[2] = '{8'd0,   4'd0, 1, 4096};
        vecs[3] = '{8'd128, 4'd1, 2, 128};
        vecs[4] = '{8'd0,   4'd1, 2, 0};
        vecs[5] = '{8'd255, 4'd3, 2, 765};
        vecs[6] = '{8'd1,   4'd1, 2, 1};

        bus.ena    = 1'b0;
        bus.duty_p = 8'd0;
        bus.duty_n = 8'd0;
        bus.start  = 1'b0;
        bus.frames = 4'd0;

        // Reset values.
        repeat (2) tick();
        check("rst_vip", int'(bus.vip), 0);
        check("rst_vin", int'(bus.vin), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_result", int'(bus.result), 0);

        // First frame after release is idle because the shadows are zero.
        bus.ena    = 1'b1;
        bus.duty_p = 8'd200;
        bus.duty_n = 8'd50;
        rst_n      = 1'b1;
        count_pwm(255, vh, nh);
        check("first_frame_vip", vh, 0);
        check("first_frame_vin", nh, 0);
        count_pwm(256, vh, nh);
        check("frame2_vip_200", vh, 200);
        check("frame2_vin_50", nh, 50);

        // Steady duty, then a mid-frame change.
        bus.duty_p = 8'd64;
        bus.duty_n = 8'd192;
        do tick(); while (model_cnt != 0);
        count_pwm(256, vh, nh);
        check("pwm_vip_64", vh, 64);
        check("pwm_vin_192", nh, 192);
        while (model_cnt != 10) tick();
        bus.duty_p = 8'd32;
        count_pwm(246, vh, nh);
        check("midframe_old_duty", vh, 54);
        count_pwm(256, vh, nh);
        check("next_frame_new_duty", vh, 32);
        check("next_frame_vin", nh, 192);

        // Measurement vectors.
        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // start while busy is ignored; start coinciding with DONE is ignored.
        loop_en    = 1'b0;
        ota_tie    = 1'b1;
        bus.frames = 4'd1;
        repeat (8) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 800) begin
            tick();
            n++;
        end
        check("sbusy_done_seen", int'(bus.done), 1);
        check("sbusy_result", int'(bus.result), 256);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_at_done_busy0", int'(bus.busy), 0);
        tick();
        check("start_at_done_busy1", int'(bus.busy), 0);
        count_done(800, dn);
        check("sbusy_single_done", dn, 0);

        // Enable dropped mid-MEASURE.
        ota_tie    = 1'b0;
        bus.frames = 4'd2;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (300) tick();
        check("ena_pre_busy", int'(bus.busy), 1);
        bus.ena = 1'b0;
        tick();
        check("ena_drop_busy", int'(bus.busy), 0);
        check("ena_drop_done", int'(bus.done), 0);
        check("ena_drop_result", int'(bus.result), 256);
        check("ena_drop_vip", int'(bus.vip), 0);
        check("ena_drop_vin", int'(bus.vin), 0);
        repeat (5) tick();
        bus.ena = 1'b1;
        count_done(1200, dn);
        check("ena_drop_no_done", dn, 0);
        check("ena_drop_result_kept", int'(bus.result), 256);

        // Reset mid-measurement.
        ota_tie    = 1'b1;
        bus.frames = 4'd4;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (299) tick();
        check("rstm_pre_busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        model_cnt = 0;
        #1;
        check("rstm_busy", int'(bus.busy), 0);
        check("rstm_done", int'(bus.done), 0);
        check("rstm_result", int'(bus.result), 0);
        check("rstm_vip", int'(bus.vip), 0);
        check("rstm_vin", int'(bus.vin), 0);
        tick();
        tick();
        rst_n = 1'b1;
        count_done(4 * 256 + 600, dn);
        check("rstm_no_done", dn, 0);
        check("rstm_busy_after", int'(bus.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
